// File: rtl/ctrl_issue_if.sv
// ctrl_issue_if: ID-stage instruction, pipeline controls and ID/EX issue outputs.
// Ports: master drives in_valid/opcode/src1/src2/dest/freeze/flush and observes ex_*,
//        id_hold, illegal, illegal_cnt; slave (the issue controller) is the mirror.
interface ctrl_issue_if #(
  parameter int OPW  = 6,
  parameter int REGW = 5,
  parameter int CNTW = 8
);
  // ID stage
  logic            in_valid;
  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] src1;
  logic [REGW-1:0] src2;
  logic [REGW-1:0] dest;
  // pipeline control
  logic            freeze;
  logic            flush;
  // ID/EX register contents
  logic            ex_valid;
  logic [3:0]      ex_exe_cmd;
  logic            ex_mem_r_en;
  logic            ex_mem_w_en;
  logic            ex_wb_en;
  logic            ex_is_imm;
  logic [1:0]      ex_br_type;
  logic [REGW-1:0] ex_dest;
  // status
  logic            id_hold;
  logic            illegal;
  logic [CNTW-1:0] illegal_cnt;

  modport master (
    output in_valid, opcode, src1, src2, dest, freeze, flush,
    input  ex_valid, ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm,
           ex_br_type, ex_dest, id_hold, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, opcode, src1, src2, dest, freeze, flush,
    output ex_valid, ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm,
           ex_br_type, ex_dest, id_hold, illegal, illegal_cnt
  );
endinterface

// File: rtl/ctrl_issue.sv
// ctrl_issue: decodes the ID instruction into the ID/EX register, inserting load-use bubbles.
// Latency 1 cycle ID->EX; id_hold (combinational) stalls upstream on freeze, hazard or STALL.
// Ports: clk, rst (sync, active-high), bus (ctrl_issue_if.slave): ID inputs, freeze/flush, ex_* out.
module ctrl_issue #(
  parameter int OPW        = 6,
  parameter int REGW       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNTW       = 8
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_issue_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cmd;
    logic            mem_r;
    logic            mem_w;
    logic            wb;
    logic            imm;
    logic [1:0]      br;
    logic [REGW-1:0] dest;
  } ex_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(7);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(8);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHL2 = OPW'(10);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(11);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(12);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(32);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(33);
  localparam logic [OPW-1:0] OP_LD   = OPW'(36);
  localparam logic [OPW-1:0] OP_ST   = OPW'(37);
  localparam logic [OPW-1:0] OP_BEZ  = OPW'(40);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(41);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(42);

  // Counter value loaded on hazard detection; the hazard cycle itself is the first bubble.
  localparam logic [1:0] LU_LAST = 2'(LU_BUBBLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  ex_t             ex_q, ex_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] ill_cnt_q, ill_cnt_d;

  ex_t  dec;
  logic legal;
  logic use_s1;
  logic use_s2;
  logic rtype;
  logic hazard;

  // Decode of the ID instruction.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.dest  = bus.dest;
    legal     = 1'b1;
    use_s1    = 1'b0;
    use_s2    = 1'b0;
    rtype     = 1'b0;
    case (bus.opcode)
      OP_NOP:  ;
      OP_ADD:  begin rtype = 1'b1; dec.cmd = 4'b0000; end
      OP_SUB:  begin rtype = 1'b1; dec.cmd = 4'b0010; end
      OP_AND:  begin rtype = 1'b1; dec.cmd = 4'b0100; end
      OP_OR:   begin rtype = 1'b1; dec.cmd = 4'b0101; end
      OP_NOR:  begin rtype = 1'b1; dec.cmd = 4'b0110; end
      OP_XOR:  begin rtype = 1'b1; dec.cmd = 4'b0111; end
      OP_SHL,
      OP_SHL2: begin rtype = 1'b1; dec.cmd = 4'b1000; end
      OP_SRA:  begin rtype = 1'b1; dec.cmd = 4'b1001; end
      OP_SRL:  begin rtype = 1'b1; dec.cmd = 4'b1010; end
      OP_ADDI: begin dec.wb = 1'b1; dec.imm = 1'b1; use_s1 = 1'b1; end
      OP_SUBI: begin dec.cmd = 4'b0010; dec.wb = 1'b1; dec.imm = 1'b1; use_s1 = 1'b1; end
      OP_LD:   begin dec.wb = 1'b1; dec.mem_r = 1'b1; dec.imm = 1'b1; use_s1 = 1'b1; end
      OP_ST:   begin dec.mem_w = 1'b1; dec.imm = 1'b1; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_BEZ:  begin dec.br = 2'b01; use_s1 = 1'b1; end
      OP_BNE:  begin dec.br = 2'b10; use_s1 = 1'b1; use_s2 = 1'b1; end
      OP_JMP:  begin dec.br = 2'b11; end
      default: begin legal = 1'b0; dec = '0; end
    endcase
    if (rtype) begin
      dec.wb = 1'b1;
      use_s1 = 1'b1;
      use_s2 = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      ex_q      <= '0;
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Next state: flush > freeze > stall/hazard > issue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_d      = ex_q;
    illegal_d = 1'b0;
    ill_cnt_d = ill_cnt_q;
    if (bus.flush) begin
      state_d = RUN;
      cnt_d   = 2'd0;
      ex_d    = '0;
    end else if (bus.freeze) begin
      // everything holds; illegal already defaults low
    end else if (state_q == STALL) begin
      ex_d  = '0;
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    end else if (hazard) begin
      ex_d    = '0;
      cnt_d   = LU_LAST;
      state_d = (LU_BUBBLES > 1) ? STALL : RUN;
    end else if (bus.in_valid && legal) begin
      ex_d = dec;
    end else begin
      ex_d = '0;
      if (bus.in_valid) begin
        illegal_d = 1'b1;
        if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNTW'(1);
      end
    end
  end

  // Outputs. The hazard looks only at RUN; a held instruction is never rechecked mid-stall.
  always_comb begin
    hazard = 1'b0;
    if (state_q == RUN && bus.in_valid && ex_q.valid && ex_q.mem_r && ex_q.dest != '0 &&
        ((use_s1 && bus.src1 == ex_q.dest) || (use_s2 && bus.src2 == ex_q.dest)))
      hazard = 1'b1;
  end

  // During reset the internal state is about to be discarded, so only freeze may hold.
  assign bus.id_hold     = rst ? bus.freeze : (bus.freeze | hazard | (state_q == STALL));
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_exe_cmd  = ex_q.cmd;
  assign bus.ex_mem_r_en = ex_q.mem_r;
  assign bus.ex_mem_w_en = ex_q.mem_w;
  assign bus.ex_wb_en    = ex_q.wb;
  assign bus.ex_is_imm   = ex_q.imm;
  assign bus.ex_br_type  = ex_q.br;
  assign bus.ex_dest     = ex_q.dest;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_ctrl_issue.sv
// tb_ctrl_issue: drives two issue controllers (LU_BUBBLES 1 and 3) with identical stimulus
// and compares both against a cycle-level reference model of the issue rules.
module tb_ctrl_issue;
  localparam int OPW = 6, REGW = 5, CNTW = 8;

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr, mw, wb, imm;
    logic [1:0] br;
    logic [4:0] dest;
    logic       ill;
    logic [7:0] cnt;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, freeze, flush;
  logic [5:0] opcode;
  logic [4:0] src1, src2, dest;

  int checks = 0;
  int errors = 0;

  ctrl_issue_if #(.OPW(OPW), .REGW(REGW), .CNTW(CNTW)) bus1 ();
  ctrl_issue_if #(.OPW(OPW), .REGW(REGW), .CNTW(CNTW)) bus3 ();

  assign bus1.in_valid = in_valid; assign bus3.in_valid = in_valid;
  assign bus1.opcode   = opcode;   assign bus3.opcode   = opcode;
  assign bus1.src1     = src1;     assign bus3.src1     = src1;
  assign bus1.src2     = src2;     assign bus3.src2     = src2;
  assign bus1.dest     = dest;     assign bus3.dest     = dest;
  assign bus1.freeze   = freeze;   assign bus3.freeze   = freeze;
  assign bus1.flush    = flush;    assign bus3.flush    = flush;

  ctrl_issue #(.OPW(OPW), .REGW(REGW), .LU_BUBBLES(1), .CNTW(CNTW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  ctrl_issue #(.OPW(OPW), .REGW(REGW), .LU_BUBBLES(3), .CNTW(CNTW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  // ---------------- reference model ----------------
  out_t m_out [2];
  int   m_pend[2] = '{0, 0};   // bubbles still owed for the current hazard
  int   lu    [2] = '{1, 3};

  function automatic out_t obs(input int k);
    if (k == 0)
      return {bus1.ex_valid, bus1.ex_exe_cmd, bus1.ex_mem_r_en, bus1.ex_mem_w_en, bus1.ex_wb_en,
              bus1.ex_is_imm, bus1.ex_br_type, bus1.ex_dest, bus1.illegal, bus1.illegal_cnt};
    return {bus3.ex_valid, bus3.ex_exe_cmd, bus3.ex_mem_r_en, bus3.ex_mem_w_en, bus3.ex_wb_en,
            bus3.ex_is_imm, bus3.ex_br_type, bus3.ex_dest, bus3.illegal, bus3.illegal_cnt};
  endfunction

  function automatic logic hold(input int k);
    return (k == 0) ? bus1.id_hold : bus3.id_hold;
  endfunction

  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] d,
                                     output out_t e, output logic ok, output logic u1,
                                     output logic u2);
    e = '0; e.v = 1'b1; e.dest = d; ok = 1'b1; u1 = 1'b0; u2 = 1'b0;
    case (int'(op))
      0: ;
      1, 3, 5, 6, 7, 8, 9, 10, 11, 12: begin
        e.wb = 1'b1; u1 = 1'b1; u2 = 1'b1;
        case (int'(op))
          1: e.cmd = 4'd0;   3: e.cmd = 4'd2;   5: e.cmd = 4'd4;  6: e.cmd = 4'd5;
          7: e.cmd = 4'd6;   8: e.cmd = 4'd7;   11: e.cmd = 4'd9; 12: e.cmd = 4'd10;
          default: e.cmd = 4'd8;
        endcase
      end
      32: begin e.wb = 1'b1; e.imm = 1'b1; u1 = 1'b1; end
      33: begin e.cmd = 4'd2; e.wb = 1'b1; e.imm = 1'b1; u1 = 1'b1; end
      36: begin e.wb = 1'b1; e.mr = 1'b1; e.imm = 1'b1; u1 = 1'b1; end
      37: begin e.mw = 1'b1; e.imm = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      40: begin e.br = 2'd1; u1 = 1'b1; end
      41: begin e.br = 2'd2; u1 = 1'b1; u2 = 1'b1; end
      42: e.br = 2'd3;
      default: begin e = '0; ok = 1'b0; end
    endcase
  endfunction

  function automatic logic m_hazard(input int k);
    out_t e; logic ok, u1, u2;
    ref_decode(opcode, dest, e, ok, u1, u2);
    return m_pend[k] == 0 && in_valid && m_out[k].v && m_out[k].mr && m_out[k].dest != 5'd0 &&
           ((u1 && src1 == m_out[k].dest) || (u2 && src2 == m_out[k].dest));
  endfunction

  function automatic logic m_hold(input int k);
    return rst ? freeze : (freeze || m_pend[k] > 0 || m_hazard(k));
  endfunction

  function automatic out_t bubble(input out_t o);
    out_t r = '0;
    r.cnt = o.cnt;
    return r;
  endfunction

  // Advance the model with the current inputs, then let the DUTs take the same edge.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      out_t e; logic ok, u1, u2, haz;
      haz = m_hazard(k);
      ref_decode(opcode, dest, e, ok, u1, u2);
      if (rst) begin
        m_out[k] = '0; m_pend[k] = 0;
      end else if (flush) begin
        m_out[k] = bubble(m_out[k]); m_pend[k] = 0;
      end else if (freeze) begin
        m_out[k].ill = 1'b0;
      end else if (m_pend[k] > 0 || haz) begin
        m_out[k]  = bubble(m_out[k]);
        m_pend[k] = (m_pend[k] > 0) ? m_pend[k] - 1 : lu[k] - 1;
      end else if (in_valid && ok) begin
        e.cnt = m_out[k].cnt; m_out[k] = e;
      end else begin
        m_out[k] = bubble(m_out[k]);
        if (in_valid) begin
          m_out[k].ill = 1'b1;
          if (m_out[k].cnt != 8'hFF) m_out[k].cnt = m_out[k].cnt + 8'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int op, input int s1, input int s2, input int d);
    in_valid = v; opcode = 6'(op); src1 = 5'(s1); src2 = 5'(s2); dest = 5'(d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; freeze = 1'b1; flush = 1'b0; drive(0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== 1'b1) begin errors++; $display("FAIL reset_hold_freeze dut%0d got %b want 1", k, hold(k)); end
    end
    freeze = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== 1'b0) begin errors++; $display("FAIL reset_hold_nofreeze dut%0d got %b want 0", k, hold(k)); end
    end
    advance(); advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== out_t'(0)) begin errors++; $display("FAIL reset_state dut%0d got %h want 0", k, obs(k)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_issue();
    out_t exp;
    drive(1, 1, 3, 4, 5);
    advance();
    exp = '0; exp.v = 1'b1; exp.wb = 1'b1; exp.dest = 5'd5;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp) begin errors++; $display("FAIL issue_add dut%0d got %h want %h", k, obs(k), exp); end
    end
    drive(1, 36, 1, 0, 7);
    advance();
    exp = '0; exp.v = 1'b1; exp.wb = 1'b1; exp.mr = 1'b1; exp.imm = 1'b1; exp.dest = 5'd7;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp) begin errors++; $display("FAIL issue_ld dut%0d got %h want %h", k, obs(k), exp); end
    end
    // every opcode value with random registers
    for (int i = 0; i < 64; i++) begin
      drive(1, i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (hold(k) !== m_hold(k)) begin errors++; $display("FAIL decode_hold op%0d dut%0d got %b want %b", i, k, hold(k), m_hold(k)); end
      end
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== m_out[k]) begin errors++; $display("FAIL decode op%0d dut%0d got %h want %h", i, k, obs(k), m_out[k]); end
      end
    end
  endtask

  task automatic test_load_use();
    int holds[2], bubs[2];
    drive(0, 0, 0, 0, 0);
    repeat (4) advance();
    drive(1, 36, 2, 0, 7);
    advance();
    drive(1, 3, 1, 7, 9);
    holds = '{0, 0}; bubs = '{0, 0};
    repeat (6) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        if (hold(k) === 1'b1) holds[k]++;
        checks++;
        if (hold(k) !== m_hold(k)) begin errors++; $display("FAIL lu_hold dut%0d got %b want %b", k, hold(k), m_hold(k)); end
      end
      advance();
      for (int k = 0; k < 2; k++) if (obs(k).v === 1'b0) bubs[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (holds[k] != lu[k]) begin errors++; $display("FAIL lu_hold_cycles dut%0d got %0d want %0d", k, holds[k], lu[k]); end
      checks++;
      if (bubs[k] != lu[k]) begin errors++; $display("FAIL lu_bubbles dut%0d got %0d want %0d", k, bubs[k], lu[k]); end
      checks++;
      if (obs(k).v !== 1'b1 || obs(k).cmd !== 4'b0010 || obs(k).dest !== 5'd9) begin
        errors++; $display("FAIL lu_sub_issue dut%0d got %h", k, obs(k));
      end
    end
  endtask

  task automatic test_no_hazard();
    drive(1, 36, 1, 0, 0); advance();
    drive(1, 1, 0, 0, 4); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== 1'b0) begin errors++; $display("FAIL r0_no_hold dut%0d got %b want 0", k, hold(k)); end
    end
    advance();
    drive(1, 36, 1, 0, 7); advance();
    drive(1, 42, 7, 7, 3); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== 1'b0) begin errors++; $display("FAIL jmp_no_hold dut%0d got %b want 0", k, hold(k)); end
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k).v !== 1'b1 || obs(k).br !== 2'd3) begin errors++; $display("FAIL jmp_issue dut%0d got %h", k, obs(k)); end
    end
  endtask

  task automatic test_illegal_sat();
    int pulses = 0;
    rst = 1'b1; advance(); rst = 1'b0;
    drive(1, 63, 1, 2, 3);
    repeat (300) begin
      advance();
      if (obs(0).ill === 1'b1) pulses++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== m_out[k]) begin errors++; $display("FAIL illegal_step dut%0d got %h want %h", k, obs(k), m_out[k]); end
      end
    end
    checks++;
    if (pulses != 300) begin errors++; $display("FAIL illegal_pulses got %0d want 300", pulses); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k).cnt !== 8'd255) begin errors++; $display("FAIL illegal_sat dut%0d got %0d want 255", k, obs(k).cnt); end
    end
  endtask

  task automatic test_flush_freeze();
    out_t held;
    rst = 1'b1; advance(); rst = 1'b0;
    drive(1, 36, 2, 0, 7); advance();
    drive(1, 3, 1, 7, 9); advance();   // dut3 now stalled with two bubbles left
    flush = 1'b1; #1;
    checks++;
    if (hold(1) !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", hold(1)); end
    advance();
    flush = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== freeze || obs(k).v !== 1'b0) begin
        errors++; $display("FAIL flush_stall dut%0d hold %b valid %b want %b 0", k, hold(k), obs(k).v, freeze);
      end
    end
    freeze = 1'b1; #1;
    checks++;
    if (hold(1) !== 1'b1) begin errors++; $display("FAIL freeze_hold got %b want 1", hold(1)); end
    freeze = 1'b0;
    drive(1, 1, 1, 2, 6); advance();
    held = obs(1);
    freeze = 1'b1; drive(1, 63, 0, 0, 0); advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== m_out[k]) begin errors++; $display("FAIL freeze_illegal dut%0d got %h want %h", k, obs(k), m_out[k]); end
    end
    checks++;
    if (obs(1).v !== 1'b1 || obs(1).dest !== 5'd6 || obs(1).cnt !== 8'd0) begin
      errors++; $display("FAIL freeze_holds got %h want %h", obs(1), held);
    end
    flush = 1'b1; drive(1, 1, 1, 2, 6); advance();
    checks++;
    if (obs(1).v !== 1'b0) begin errors++; $display("FAIL freeze_flush got valid %b want 0", obs(1).v); end
    freeze = 1'b0; drive(1, 63, 0, 0, 0); advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== out_t'(0)) begin errors++; $display("FAIL flush_illegal dut%0d got %h want 0", k, obs(k)); end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b1; advance(); rst = 1'b0;
    drive(1, 63, 0, 0, 0);
    repeat (9) advance();
    drive(1, 36, 2, 0, 7); advance();
    drive(1, 3, 1, 7, 9); advance();
    checks++;
    if (obs(1).cnt !== 8'd9 || hold(1) !== 1'b1) begin
      errors++; $display("FAIL pre_reset cnt %0d hold %b want 9 1", obs(1).cnt, hold(1));
    end
    rst = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hold(k) !== 1'b0) begin errors++; $display("FAIL reset_mid_hold dut%0d got %b want 0", k, hold(k)); end
    end
    advance();
    rst = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== out_t'(0) || hold(k) !== 1'b0) begin
        errors++; $display("FAIL reset_mid_stall dut%0d got %h hold %b want 0 0", k, obs(k), hold(k));
      end
    end
    advance();
    checks++;
    if (obs(1).v !== 1'b1 || obs(1).cmd !== 4'b0010) begin errors++; $display("FAIL post_reset_issue got %h", obs(1)); end
  endtask

  task automatic test_random();
    int ops[20] = '{0, 1, 3, 5, 9, 10, 12, 32, 33, 36, 36, 36, 36, 37, 40, 41, 42, 63, 2, 50};
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 19)],
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (hold(k) !== m_hold(k)) begin errors++; $display("FAIL rand_hold cyc%0d dut%0d got %b want %b", i, k, hold(k), m_hold(k)); end
      end
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== m_out[k]) begin errors++; $display("FAIL rand_out cyc%0d dut%0d got %h want %h", i, k, obs(k), m_out[k]); end
      end
    end
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    m_out[0] = '0; m_out[1] = '0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_issue();
    test_load_use();
    test_no_hazard();
    test_illegal_sat();
    test_flush_freeze();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_issue.md
CTRL_ISSUE -- requirements
Module: ctrl_issue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - OPW, 6: opcode width.
 - REGW, 5: register address width.
 - LU_BUBBLES, 1: bubbles inserted on a load-use hazard; legal range 1..3.
 - CNTW, 8: width of the illegal-opcode counter.
REQ-002 Ports (name, direction, width, meaning), one per line:
 - clk, in, 1: the single clock; all state updates on its rising edge.
 - rst, in, 1: reset, synchronous and active-high.
 - in_valid, in, 1: ID stage holds an instruction.
 - opcode, in, OPW: ID opcode.
 - src1, in, REGW: ID source register 1.
 - src2, in, REGW: ID source register 2.
 - dest, in, REGW: ID destination register.
 - freeze, in, 1: downstream stall.
 - flush, in, 1: branch taken; kill ID and EX.
 - ex_valid, out, 1: ID/EX register holds a real instruction.
 - ex_exe_cmd, out, 4: ALU command.
 - ex_mem_r_en, out, 1: memory read enable.
 - ex_mem_w_en, out, 1: memory write enable.
 - ex_wb_en, out, 1: writeback enable.
 - ex_is_imm, out, 1: immediate operand select.
 - ex_br_type, out, 2: branch type.
 - ex_dest, out, REGW: destination register of the EX instruction.
 - id_hold, out, 1: combinational; upstream holds PC and IF/ID.
 - illegal, out, 1: one-cycle pulse when an illegal opcode issues.
 - illegal_cnt, out, CNTW: saturating count of illegal opcodes.

Function
REQ-003 Decode table (cmd / flags / sources read):
 - 0 NOP: 0000 / none / none.
 - 1 ADD 0000, 3 SUB 0010, 5 AND 0100, 6 OR 0101, 7 NOR 0110, 8 XOR 0111, 9 and 10 SHL 1000, 11 SRA 1001, 12 SRL 1010: WB / s1,s2.
 - 32 ADDI 0000, 33 SUBI 0010: WB,IMM / s1.
 - 36 LD 0000: WB,MR,IMM / s1.
 - 37 ST 0000: MW,IMM / s1,s2.
 - 40 BEZ br=01 / s1; 41 BNE br=10 / s1,s2; 42 JMP br=11 / none; cmd=0000 for all three.
 - Any other opcode is illegal.
REQ-004 All outputs are deterministic; no x or z values are ever driven.
REQ-005 Bubble definition: ex_valid=0 and every ex_* output = 0.
REQ-006 Issue: in_valid=1 and no hold/flush -> decoded fields appear on ex_* at the next edge, with ex_valid=1 and ex_dest=dest; latency is 1 cycle.
REQ-007 NOP issues with ex_valid=1 and all flags 0.
REQ-008 Illegal opcode issues as a bubble, and illegal pulses for one cycle coincident with that edge.
REQ-009 illegal_cnt increments by 1 per illegal issue and saturates at 2^CNTW-1.
REQ-010 in_valid=0 with no hold -> a bubble is loaded.
REQ-011 Hazard condition, evaluated in RUN only:
 - in_valid & ex_valid & ex_mem_r_en & ex_dest!=0, and
 - (uses_s1 & src1==ex_dest) | (uses_s2 & src2==ex_dest).
REQ-012 FSM states RUN and STALL, with a 2-bit bubble counter.
REQ-013 RUN with hazard -> load a bubble, counter=LU_BUBBLES-1, go to STALL if LU_BUBBLES>1, else remain in RUN; id_hold=1 in this cycle.
REQ-014 STALL -> load a bubble and id_hold=1; counter decrements; when counter==1 at the edge, go to RUN with counter=0.
REQ-015 The hazard is never re-evaluated in STALL; the held instruction issues in the first RUN cycle after the stall.
REQ-016 The total number of bubbles per hazard equals LU_BUBBLES exactly.
REQ-017 id_hold = freeze | hazard-in-RUN | (state==STALL).
REQ-018 Priority order: rst > flush > freeze > hazard > issue.
REQ-019 flush: ID/EX loads a bubble, FSM goes to RUN, counter=0, no illegal pulse or count; the ID instruction is discarded, even when an illegal opcode is present.
REQ-020 freeze without flush: ID/EX, FSM, counter and illegal_cnt hold; illegal=0; id_hold=1.
REQ-021 Simultaneous freeze and flush: flush wins.
REQ-022 A hazard coincident with freeze: freeze takes effect and the hazard is re-evaluated on the next unfrozen cycle.

Reset
REQ-023 When rst=1 at an edge, in the next cycle:
 - ID/EX register = bubble,
 - FSM = RUN,
 - counter = 0,
 - illegal = 0,
 - illegal_cnt = 0.
REQ-024 Reset mid-STALL or mid-freeze aborts the operation; no pending state survives reset.
REQ-025 During reset, id_hold is driven by freeze only.

Verification
REQ-026 ADD(1) src 3,4 dest 5, then LD(36) dest 7 -> ex_exe_cmd=0000, ex_wb_en=1, ex_dest=5; next cycle ex_mem_r_en=1, ex_is_imm=1, ex_dest=7.
REQ-027 LD dest 7 in EX, ID holds SUB with src2=7:
 - LU_BUBBLES=1 -> id_hold=1 for 1 cycle, 1 bubble, then SUB issues.
 - LU_BUBBLES=3 -> id_hold=1 for 3 cycles, 3 bubbles.
REQ-028 LD dest 0 in EX followed by ADD reading r0 -> no hold. JMP after LD dest 7 with src1=7 -> no hold, since JMP reads no sources.
REQ-029 Opcode 63 issued 300 times, CNTW=8 -> 300 illegal pulses; illegal_cnt stops at 255; ex_valid=0 on each of those issues.
REQ-030 flush during STALL with counter=2 -> next cycle RUN, bubble, id_hold=freeze. freeze+flush together -> bubble loaded.
REQ-031 rst asserted for 1 cycle mid-STALL with illegal_cnt=9 -> all outputs 0 and FSM=RUN in the next cycle.
